cut_stream_adapter: RTL and testbench
=====================================

# cut_stream_adapter

Streaming front-end that sits directly downstream of the autotest controller and in front of the hash core under test. It takes the parallel test vector and the `rst_cut` run control from the controller. It serialises the vector into R-bit message chunks over a valid/ready handshake, waits for the core's digest, and latches it. It then returns the digest with an `end_cut` completion flag, the pair the controller samples.

## Interface
- `DATA_WIDTH`, default 128: test-vector width in bits; must be a multiple of `R`.
- `N`, default 88: digest width in bits.
- `R`, default 8: message chunk width in bits.
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `rst_cut` input 1: run control from the controller; 1 = hold/clear, falling to 0 = start one run.
- `input_to_cut` input DATA_WIDTH: test vector; sampled only in CLEAR.
- `end_cut` output 1: run complete; held high in DONE.
- `output_from_cut` output N: latched digest; valid while `end_cut`=1.
- `core_clear` output 1: one-cycle init pulse to the hash core.
- `m_data` output R: message chunk to the core, MSB-first from the vector.
- `m_valid` output 1: chunk valid.
- `m_last` output 1: qualifies the final chunk; only meaningful with `m_valid`.
- `m_ready` input 1: core accepts chunk.
- `h_digest` input N: core digest.
- `h_valid` input 1: digest valid (single-cycle or level; first sample wins).

## Operation
- `CHUNKS` = `DATA_WIDTH/R`. Chunk counter width is `$clog2(CHUNKS)+1`. The shift register is DATA_WIDTH bits.
- **IDLE**: all outputs are 0 and the counter is 0. If `rst_cut`=0, go to CLEAR.
- **CLEAR** (exactly 1 cycle):
  - `core_clear`=1.
  - Load the shift register from `input_to_cut` and clear the counter.
  - Go to SEND.
- **SEND**:
  - `m_valid`=1.
  - `m_data` = shift register [DATA_WIDTH-1 -: R].
  - `m_last`=1 when counter = `CHUNKS`-1.
  - Handshake on `m_valid` & `m_ready`: shift left by R and increment the counter. If the accepted chunk was the last one, go to WAIT.
- **WAIT**:
  - `m_valid`=0.
  - On `h_valid`=1, register `h_digest` into `output_from_cut` and go to DONE.
- **DONE**: `end_cut`=1, and `output_from_cut` is held. Stay in DONE until `rst_cut`=1.
- `rst_cut`=1 in any non-IDLE state has priority:
  - Next state is IDLE.
  - `m_valid`, `m_last`, `end_cut` and `core_clear` go to 0, and `output_from_cut` is cleared.
  - This applies even in the same cycle as a handshake or `h_valid`; that event is discarded.
- `h_valid` outside WAIT is ignored. `m_ready` outside SEND is ignored.
- Changes to `input_to_cut` after CLEAR have no effect on the current run.

## Timing
- All outputs are registered.
- Asynchronous reset (`rst`=0) gives state IDLE and every output 0, including `output_from_cut`=0. This holds mid-run with no partial completion.
- From the first edge that samples `rst_cut`=0 in IDLE:
  - `core_clear` is high in cycle +1.
  - `m_valid` rises in cycle +2.
- `m_data`, `m_last` and `m_valid` are stable while `m_valid`=1 and `m_ready`=0. The next chunk is presented the cycle after a handshake.
- Minimum SEND duration is `CHUNKS` cycles, with `m_ready` tied to 1.
- `end_cut` and `output_from_cut` update on the edge after `h_valid` is sampled in WAIT. That is one cycle of latency.
- Leaving DONE: `end_cut` falls on the edge after `rst_cut`=1 is sampled.

## Configuration
- Macro `CUT_CYCLE_COUNT_EN`.
- **Defined**: adds the port `cut_cycles` (output, 32 bits).
  - Cleared in IDLE.
  - Increments once per cycle spent in CLEAR, SEND and WAIT; saturates at 0xFFFFFFFF.
  - Frozen in DONE and readable alongside `end_cut`.
- **Undefined**: the port and the counter are absent. Behaviour is otherwise identical.

## Test plan
1. **Basic run.** `DATA_WIDTH`=16, R=8, N=8. Stimulus: `input_to_cut`=0xA55A, `m_ready`=1, `rst_cut` falls. Required response:
   - `core_clear` is pulsed.
   - `m_data`=0xA5 (`m_last`=0), then 0x5A (`m_last`=1).
   - The bench drives `h_digest`=0x3C with `h_valid` on the 3rd WAIT cycle. One cycle later `end_cut`=1 and `output_from_cut`=0x3C.
2. **Backpressure.** Same setup, with `m_ready`=0 for 3 cycles on chunk 0. Required response: `m_data`=0xA5 and `m_valid`=1 held for all 3 cycles; 0x5A appears only after `m_ready`=1.
3. **Abort.** Assert `rst_cut`=1 during SEND, in the same cycle as a handshake. Required response: next cycle IDLE, `m_valid`=0, `end_cut`=0. A later `h_valid` is ignored, and re-release of `rst_cut` restarts from chunk 0xA5.
4. **Async reset.** Drive `rst`=0 mid-WAIT. Required response: all outputs 0 immediately (no clock edge); after release the block is in IDLE.
5. **Stale digest.** Pulse `h_valid` during SEND. Required response: ignored; completion occurs only on the later `h_valid` in WAIT.
6. **`CUT_CYCLE_COUNT_EN` defined.** Repeat scenario 1. Required response: `cut_cycles`=6 (1 CLEAR + 2 SEND + 3 WAIT), held in DONE and cleared to 0 after `rst_cut`=1.

Source files
------------

// File: rtl/cut_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : cut_stream_adapter
//  Purpose  : Sits between the autotest controller and the hash core under
//             test. Captures the parallel test vector and streams it MSB-first
//             as R-bit chunks over valid/ready. It then waits for the core's
//             digest, latches it and raises end_cut until the controller
//             re-asserts rst_cut.
//  Options  : CUT_CYCLE_COUNT_EN adds a 32-bit saturating busy-cycle counter
//             on port cut_cycles (cycles spent in CLEAR, SEND and WAIT).
//  Revision : 1.0 - initial release
// ============================================================================
module cut_stream_adapter #(
  parameter int DATA_WIDTH = 128,
  parameter int N          = 88,
  parameter int R          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_cut,
  input  logic [DATA_WIDTH-1:0] input_to_cut,
  output logic                  end_cut,
  output logic [N-1:0]          output_from_cut,
  output logic                  core_clear,
  output logic [R-1:0]          m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic [N-1:0]          h_digest,
  input  logic                  h_valid
`ifdef CUT_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cut_cycles
`endif
);

  // DATA_WIDTH is expected to be an exact multiple of R.
  localparam int               CHUNKS   = DATA_WIDTH / R;
  localparam int               CNT_W    = $clog2(CHUNKS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N-1:0]          digest_q, digest_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  end_q, end_d;
  logic                  clear_q, clear_d;
  logic                  abort_w;
  logic                  accept_w;

  // rst_cut outside IDLE wins over any handshake or digest in the same cycle.
  assign abort_w  = rst_cut && (state_q != S_IDLE);
  assign accept_w = valid_q && m_ready;

  // Next-state, shift register, chunk counter and digest capture.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    if (abort_w) begin
      state_d  = S_IDLE;
      sreg_d   = '0;
      cnt_d    = '0;
      digest_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sreg_d   = '0;
          cnt_d    = '0;
          digest_d = '0;
          if (!rst_cut) begin
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          // The vector is captured here only; later changes do not matter.
          sreg_d  = input_to_cut;
          cnt_d   = '0;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (accept_w) begin
            // Shifting left leaves zeros behind, so m_data reads 0 after
            // the final chunk has gone.
            sreg_d = sreg_q << R;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (h_valid) begin
            digest_d = h_digest;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d  = S_IDLE;
          sreg_d   = '0;
          cnt_d    = '0;
          digest_d = '0;
        end
      endcase
    end
  end

  // Output flags are decoded from the next state so they leave a flop.
  always_comb begin
    valid_d = (state_d == S_SEND);
    last_d  = (state_d == S_SEND) && (cnt_d == LAST_IDX);
    end_d   = (state_d == S_DONE);
    clear_d = (state_d == S_CLEAR);
  end

  // State and output registers; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      end_q    <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      end_q    <= end_d;
      clear_q  <= clear_d;
    end
  end

  assign m_data          = sreg_q[DATA_WIDTH-1 -: R];
  assign m_valid         = valid_q;
  assign m_last          = last_q;
  assign end_cut         = end_q;
  assign core_clear      = clear_q;
  assign output_from_cut = digest_q;

`ifdef CUT_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Busy-cycle count: zero in IDLE, frozen in DONE, saturating.
  always_comb begin
    cyc_d = cyc_q;
    if (state_d == S_IDLE) begin
      cyc_d = '0;
    end else if (((state_q == S_CLEAR) || (state_q == S_SEND) ||
                  (state_q == S_WAIT)) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cut_cycles = cyc_q;
`else
  // Busy-cycle counter is not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cut_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cut_stream_adapter
//  Purpose  : Directed scenarios plus randomized traffic for
//             cut_stream_adapter (16-bit vector, 8-bit chunks, 8-bit digest),
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cut_stream_adapter;

  localparam int DW = 16;
  localparam int RW = 8;
  localparam int NW = 8;
  localparam int CH = DW / RW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rst_cut = 1'b1;
  logic [DW-1:0] input_to_cut = '0;
  logic          end_cut;
  logic [NW-1:0] output_from_cut;
  logic          core_clear;
  logic [RW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [NW-1:0] h_digest = '0;
  logic          h_valid = 1'b0;
`ifdef CUT_CYCLE_COUNT_EN
  logic [31:0]   cut_cycles;
`endif

  int errors = 0;
  int checks = 0;

  cut_stream_adapter #(.DATA_WIDTH(DW), .N(NW), .R(RW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rst_cut         (rst_cut),
    .input_to_cut    (input_to_cut),
    .end_cut         (end_cut),
    .output_from_cut (output_from_cut),
    .core_clear      (core_clear),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_last          (m_last),
    .m_ready         (m_ready),
    .h_digest        (h_digest),
    .h_valid         (h_valid)
`ifdef CUT_CYCLE_COUNT_EN
    ,
    .cut_cycles      (cut_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: run phase, queue of chunks still to be sent,
  // expected digest and expected busy-cycle count.
  typedef enum {P_IDLE, P_CLEAR, P_SEND, P_WAIT, P_DONE} phase_t;
  phase_t        ph = P_IDLE;
  logic [RW-1:0] chunks[$];
  logic [NW-1:0] exp_dig = '0;
  longint        exp_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE;
    chunks.delete();
    exp_dig = '0;
    exp_cyc = 0;
  endtask

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (ph != P_IDLE && rst_cut) begin
      model_reset();
    end else begin
      if ((ph == P_CLEAR || ph == P_SEND || ph == P_WAIT) && exp_cyc < 64'hFFFF_FFFF)
        exp_cyc++;
      case (ph)
        P_IDLE:  if (!rst_cut) ph = P_CLEAR;
        P_CLEAR: begin
          for (int i = CH - 1; i >= 0; i--) chunks.push_back(input_to_cut[i*RW +: RW]);
          ph = P_SEND;
        end
        P_SEND: if (m_ready) begin
          void'(chunks.pop_front());
          if (chunks.size() == 0) ph = P_WAIT;
        end
        P_WAIT: if (h_valid) begin
          exp_dig = h_digest;
          ph = P_DONE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_cycle();
    chk("m_valid", m_valid, 64'(ph == P_SEND));
    chk("core_clear", core_clear, 64'(ph == P_CLEAR));
    chk("end_cut", end_cut, 64'(ph == P_DONE));
    chk("output_from_cut", output_from_cut, exp_dig);
    if (ph == P_SEND) begin
      chk("m_data", m_data, chunks[0]);
      chk("m_last", m_last, 64'(chunks.size() == 1));
    end else if (ph == P_IDLE) begin
      chk("m_data_idle", m_data, 0);
      chk("m_last_idle", m_last, 0);
    end
`ifdef CUT_CYCLE_COUNT_EN
    chk("cut_cycles", cut_cycles, exp_cyc);
`endif
  endtask

  // One clock: model sees the current inputs, DUT is sampled at the negedge.
  task automatic step();
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic areset(input string tag);
    #1 rst = 1'b0;
    #1;
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_end_cut"}, end_cut, 0);
    chk({tag, "_core_clear"}, core_clear, 0);
    chk({tag, "_digest"}, output_from_cut, 0);
    model_reset();
    rst_cut = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_end_cut", end_cut, 0);
    chk("rst_core_clear", core_clear, 0);
    chk("rst_digest", output_from_cut, 0);
    rst = 1'b1;
    step();

    // Basic run
    input_to_cut = 16'hA55A;
    m_ready = 1'b1;
    rst_cut = 1'b0;
    step();
    chk("s1_core_clear", core_clear, 1);
    step();
    chk("s1_chunk0", m_data, 8'hA5);
    chk("s1_last0", m_last, 0);
    input_to_cut = 16'h1234;
    step();
    chk("s1_chunk1", m_data, 8'h5A);
    chk("s1_last1", m_last, 1);
    step();
    chk("s1_wait_valid", m_valid, 0);
    step();
    step();
    h_digest = 8'h3C;
    h_valid = 1'b1;
    step();
    chk("s1_end_cut", end_cut, 1);
    chk("s1_digest", output_from_cut, 8'h3C);
`ifdef CUT_CYCLE_COUNT_EN
    chk("s6_cycles", cut_cycles, 6);
`endif
    h_valid = 1'b0;
    h_digest = 8'h00;
    step();
    chk("s1_hold_end", end_cut, 1);
    chk("s1_hold_digest", output_from_cut, 8'h3C);
`ifdef CUT_CYCLE_COUNT_EN
    chk("s6_cycles_hold", cut_cycles, 6);
`endif
    rst_cut = 1'b1;
    step();
    chk("s1_leave_end", end_cut, 0);
    chk("s1_leave_digest", output_from_cut, 0);
`ifdef CUT_CYCLE_COUNT_EN
    chk("s6_cycles_clr", cut_cycles, 0);
`endif

    // Backpressure on chunk 0, with a stale digest pulse during SEND
    input_to_cut = 16'hA55A;
    m_ready = 1'b0;
    rst_cut = 1'b0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("s2_bp_data", m_data, 8'hA5);
      chk("s2_bp_valid", m_valid, 1);
      h_valid = (k == 1);
      h_digest = 8'h77;
      if (k == 2) m_ready = 1'b1;
      step();
    end
    h_valid = 1'b0;
    chk("s2_chunk1", m_data, 8'h5A);
    chk("s5_no_early_end", end_cut, 0);
    step();
    h_digest = 8'hC3;
    h_valid = 1'b1;
    step();
    chk("s5_digest", output_from_cut, 8'hC3);
    h_valid = 1'b0;
    areset("s4_done");

    // Abort in SEND coinciding with a handshake
    step();
    input_to_cut = 16'hA55A;
    m_ready = 1'b1;
    rst_cut = 1'b0;
    step();
    step();
    rst_cut = 1'b1;
    step();
    chk("s3_abort_valid", m_valid, 0);
    chk("s3_abort_end", end_cut, 0);
    h_digest = 8'h99;
    h_valid = 1'b1;
    step();
    chk("s3_ignore_hvalid", end_cut, 0);
    h_valid = 1'b0;
    rst_cut = 1'b0;
    step();
    step();
    chk("s3_restart_chunk", m_data, 8'hA5);
    step();
    step();

    // Async reset mid-WAIT, then a fresh start from IDLE
    areset("s4_wait");
    step();
    rst_cut = 1'b0;
    step();
    chk("s4_restart_clear", core_clear, 1);
    rst_cut = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      input_to_cut = DW'($urandom);
      h_digest = NW'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      h_valid = ($urandom_range(0, 4) == 0);
      case (ph)
        P_IDLE:  rst_cut = ($urandom_range(0, 2) == 0);
        P_DONE:  rst_cut = ($urandom_range(0, 1) == 0);
        default: rst_cut = ($urandom_range(0, 24) == 0);
      endcase
      if ($urandom_range(0, 99) == 0) areset("rnd");
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
